// File: rtl/object_centroid.sv
// Post-frame centroid stage: scans labels 1..num_labels-1 of the feature table and streams one
// {id, x, y, area} record per surviving object. Define CENTROID_ROUND_EN for round-half-up centroids.
module object_centroid #(
  parameter int WORD_SIZE = 8,
  parameter int OBJ_WIDTH = 128,
  parameter int ACC_WIDTH = 64,
  parameter int MIN_AREA  = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [WORD_SIZE-1:0]   num_labels,
  output logic [WORD_SIZE-1:0]   tbl_rd_addr,
  input  logic [3*OBJ_WIDTH-1:0] tbl_rd_data,
  output logic                   obj_valid,
  input  logic                   obj_ready,
  output logic [WORD_SIZE-1:0]   obj_id,
  output logic [31:0]            obj_x,
  output logic [31:0]            obj_y,
  output logic [31:0]            obj_area,
  output logic                   busy,
  output logic                   done,
  output logic [2:0]             dbg_state
);

  // Handshake: obj_valid rises in OUT with id/x/y/area stable and stays high until obj_ready is
  // seen high on a rising edge; that edge transfers the record and obj_valid drops the next cycle.

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_WAIT, S_CHECK, S_PRE, S_DIV, S_OUT, S_FIN
  } state_t;

  localparam int CW = $clog2(ACC_WIDTH);
  localparam logic [ACC_WIDTH-1:0] MIN_P = ACC_WIDTH'(MIN_AREA);

  state_t                 state_q, state_d;
  logic [WORD_SIZE-1:0]   lim_q, lim_d;
  logic [WORD_SIZE-1:0]   label_q, label_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [ACC_WIDTH-1:0]   p_q, p_d;
  logic [ACC_WIDTH-1:0]   x_quo_q, x_quo_d, y_quo_q, y_quo_d;
  logic [ACC_WIDTH-1:0]   x_rem_q, x_rem_d, y_rem_q, y_rem_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [WORD_SIZE-1:0]   obj_id_q, obj_id_d;
  logic [31:0]            obj_x_q, obj_x_d, obj_y_q, obj_y_d, obj_area_q, obj_area_d;

  logic [ACC_WIDTH-1:0]   rd_p, rd_x, rd_y;
  logic                   unused_rd;
  logic [2*ACC_WIDTH-1:0] x_step, y_step;
  logic                   last_label;

  // One restoring-division step: returns {remainder, quotient/dividend shift register}.
  function automatic logic [2*ACC_WIDTH-1:0] div_step(input logic [ACC_WIDTH-1:0] rem,
                                                      input logic [ACC_WIDTH-1:0] quo,
                                                      input logic [ACC_WIDTH-1:0] dvs);
    logic [ACC_WIDTH:0] sh;
    logic               qb;
    sh = {rem, quo[ACC_WIDTH-1]};
    qb = (sh >= {1'b0, dvs});
    if (qb) sh = sh - {1'b0, dvs};
    return {sh[ACC_WIDTH-1:0], quo[ACC_WIDTH-2:0], qb};
  endfunction

  function automatic logic [31:0] sat32(input logic [ACC_WIDTH-1:0] v);
    return (|v[ACC_WIDTH-1:32]) ? 32'hFFFF_FFFF : v[31:0];
  endfunction

  assign rd_p      = tbl_rd_data[0 +: ACC_WIDTH];
  assign rd_x      = tbl_rd_data[OBJ_WIDTH +: ACC_WIDTH];
  assign rd_y      = tbl_rd_data[2*OBJ_WIDTH +: ACC_WIDTH];
  assign unused_rd = ^tbl_rd_data;

  assign x_step     = div_step(x_rem_q, x_quo_q, p_q);
  assign y_step     = div_step(y_rem_q, y_quo_q, p_q);
  assign last_label = (label_q == '1) || ((label_q + WORD_SIZE'(1)) == lim_q);

  always_comb begin
    state_d    = state_q;
    lim_d      = lim_q;
    label_d    = label_q;
    busy_d     = busy_q & ~done_q;
    done_d     = 1'b0;
    p_d        = p_q;
    x_quo_d    = x_quo_q;
    y_quo_d    = y_quo_q;
    x_rem_d    = x_rem_q;
    y_rem_d    = y_rem_q;
    cnt_d      = cnt_q;
    obj_id_d   = obj_id_q;
    obj_x_d    = obj_x_q;
    obj_y_d    = obj_y_q;
    obj_area_d = obj_area_q;
    case (state_q)
      S_IDLE: begin
        // busy_q is still high during the done cycle, so a start coincident with done is dropped.
        if (start && !busy_q) begin
          lim_d   = num_labels;
          label_d = WORD_SIZE'(1);
          busy_d  = 1'b1;
          state_d = (num_labels <= WORD_SIZE'(1)) ? S_FIN : S_READ;
        end
      end
      S_READ: state_d = S_WAIT;
      S_WAIT: state_d = S_CHECK;
      S_CHECK: begin
        if (rd_p == '0 || rd_p < MIN_P) begin
          if (label_q != '1) label_d = label_q + WORD_SIZE'(1);
          state_d = last_label ? S_FIN : S_READ;
        end else begin
          p_d        = rd_p;
          x_quo_d    = rd_x;
          y_quo_d    = rd_y;
          x_rem_d    = '0;
          y_rem_d    = '0;
          cnt_d      = '0;
          obj_id_d   = label_q;
          obj_area_d = sat32(rd_p);
`ifdef CENTROID_ROUND_EN
          state_d    = S_PRE;
`else
          state_d    = S_DIV;
`endif
        end
      end
      S_PRE: begin
        x_quo_d = x_quo_q + (p_q >> 1);
        y_quo_d = y_quo_q + (p_q >> 1);
        state_d = S_DIV;
      end
      S_DIV: begin
        {x_rem_d, x_quo_d} = x_step;
        {y_rem_d, y_quo_d} = y_step;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(ACC_WIDTH-1)) begin
          obj_x_d = sat32(x_step[ACC_WIDTH-1:0]);
          obj_y_d = sat32(y_step[ACC_WIDTH-1:0]);
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (obj_ready) begin
          if (label_q != '1) label_d = label_q + WORD_SIZE'(1);
          state_d = last_label ? S_FIN : S_READ;
        end
      end
      S_FIN: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      lim_q      <= '0;
      label_q    <= WORD_SIZE'(1);
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      p_q        <= '0;
      x_quo_q    <= '0;
      y_quo_q    <= '0;
      x_rem_q    <= '0;
      y_rem_q    <= '0;
      cnt_q      <= '0;
      obj_id_q   <= '0;
      obj_x_q    <= '0;
      obj_y_q    <= '0;
      obj_area_q <= '0;
    end else begin
      state_q    <= state_d;
      lim_q      <= lim_d;
      label_q    <= label_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      p_q        <= p_d;
      x_quo_q    <= x_quo_d;
      y_quo_q    <= y_quo_d;
      x_rem_q    <= x_rem_d;
      y_rem_q    <= y_rem_d;
      cnt_q      <= cnt_d;
      obj_id_q   <= obj_id_d;
      obj_x_q    <= obj_x_d;
      obj_y_q    <= obj_y_d;
      obj_area_q <= obj_area_d;
    end
  end

  assign tbl_rd_addr = (state_q inside {S_READ, S_WAIT, S_CHECK}) ? label_q : '0;
  assign obj_valid   = (state_q == S_OUT);
  assign obj_id      = obj_id_q;
  assign obj_x       = obj_x_q;
  assign obj_y       = obj_y_q;
  assign obj_area    = obj_area_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign dbg_state   = state_q;

endmodule
